// File: rtl/datapath_sequencer.sv
// Control sequencer for the regfile/shifter/ALU datapath: steps one instruction per start,
// driving registered load/select/write strobes, a retired-instruction count and an illegal-opcode flag.
module datapath_sequencer #(
    parameter int unsigned ICNT_W       = 16,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic [2:0]        opcode,
    input  logic [1:0]        op,
    output logic              w,
    output logic [2:0]        nsel,
    output logic [1:0]        vsel,
    output logic              loada,
    output logic              loadb,
    output logic              asel,
    output logic              bsel,
    output logic              loadc,
    output logic              loads,
    output logic              write,
    output logic              err,
    output logic [ICNT_W-1:0] icount
);

    localparam int unsigned INSTR_W = 5;

    localparam logic [INSTR_W-1:0] I_MOV_IMM = 5'b110_10;
    localparam logic [INSTR_W-1:0] I_MOV_REG = 5'b110_00;
    localparam logic [INSTR_W-1:0] I_ADD     = 5'b101_00;
    localparam logic [INSTR_W-1:0] I_CMP     = 5'b101_01;
    localparam logic [INSTR_W-1:0] I_AND     = 5'b101_10;
    localparam logic [INSTR_W-1:0] I_MVN     = 5'b101_11;

    localparam logic [2:0] NSEL_RM = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RN = 3'b100;
    localparam logic [1:0] VSEL_C  = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WR_IMM,
        S_WR_REG,
        S_ERR
    } state_t;

    state_t              state, state_nx;
    logic [INSTR_W-1:0]  ir, ir_nx;
    logic                err_nx;
    logic [ICNT_W-1:0]   icount_nx;
    logic                retire;

    logic                w_nx, loada_nx, loadb_nx, asel_nx, bsel_nx;
    logic                loadc_nx, loads_nx, write_nx;
    logic [2:0]          nsel_nx;
    logic [1:0]          vsel_nx;

    // State, latched instruction, flags and the registered strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_WAIT;
            ir     <= '0;
            err    <= 1'b0;
            icount <= '0;
            w      <= 1'b1;
            nsel   <= '0;
            vsel   <= '0;
            loada  <= 1'b0;
            loadb  <= 1'b0;
            asel   <= 1'b0;
            bsel   <= 1'b0;
            loadc  <= 1'b0;
            loads  <= 1'b0;
            write  <= 1'b0;
        end else begin
            state  <= state_nx;
            ir     <= ir_nx;
            err    <= err_nx;
            icount <= icount_nx;
            w      <= w_nx;
            nsel   <= nsel_nx;
            vsel   <= vsel_nx;
            loada  <= loada_nx;
            loadb  <= loadb_nx;
            asel   <= asel_nx;
            bsel   <= bsel_nx;
            loadc  <= loadc_nx;
            loads  <= loads_nx;
            write  <= write_nx;
        end
    end

    // Next state, instruction capture, retire and illegal handling
    always_comb begin
        state_nx  = state;
        ir_nx     = ir;
        err_nx    = err;
        retire    = 1'b0;
        case (state)
            S_WAIT: begin
                if (s) begin
                    ir_nx    = {opcode, op};
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                case (ir)
                    I_MOV_IMM:              state_nx = S_WR_IMM;
                    I_MOV_REG, I_MVN:       state_nx = S_GET_B;
                    I_ADD, I_AND, I_CMP:    state_nx = S_GET_A;
                    default: begin
                        err_nx   = 1'b1;
                        state_nx = ILLEGAL_TRAP ? S_ERR : S_WAIT;
                    end
                endcase
            end
            S_GET_A: state_nx = S_GET_B;
            S_GET_B: state_nx = S_ALU;
            S_ALU: begin
                if (ir == I_CMP) begin
                    state_nx = S_WAIT;
                    retire   = 1'b1;
                end else begin
                    state_nx = S_WR_REG;
                end
            end
            S_WR_IMM, S_WR_REG: begin
                state_nx = S_WAIT;
                retire   = 1'b1;
            end
            S_ERR:   state_nx = S_ERR;
            default: state_nx = S_WAIT;
        endcase
        icount_nx = retire ? icount + ICNT_W'(1) : icount;
    end

    // Strobes are decoded from the next state so they register in step with it
    always_comb begin
        w_nx     = 1'b0;
        nsel_nx  = '0;
        vsel_nx  = VSEL_C;
        loada_nx = 1'b0;
        loadb_nx = 1'b0;
        asel_nx  = 1'b0;
        bsel_nx  = 1'b0;
        loadc_nx = 1'b0;
        loads_nx = 1'b0;
        write_nx = 1'b0;
        case (state_nx)
            S_WAIT: w_nx = 1'b1;
            S_GET_A: begin
                nsel_nx  = NSEL_RN;
                loada_nx = 1'b1;
            end
            S_GET_B: begin
                nsel_nx  = NSEL_RM;
                loadb_nx = 1'b1;
            end
            S_ALU: begin
                if (ir_nx == I_MOV_REG) begin
                    asel_nx  = 1'b1;
                    loadc_nx = 1'b1;
                end else if (ir_nx == I_CMP) begin
                    loads_nx = 1'b1;
                end else begin
                    loadc_nx = 1'b1;
                    loads_nx = 1'b1;
                end
            end
            S_WR_IMM: begin
                nsel_nx  = NSEL_RN;
                vsel_nx  = VSEL_IMM;
                write_nx = 1'b1;
            end
            S_WR_REG: begin
                nsel_nx  = NSEL_RD;
                vsel_nx  = VSEL_C;
                write_nx = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
